// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the oversampling UART receiver.
package uart_pkg;

  // Line parity selection as presented on i_parity_mode.
  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_e;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  // Supported oversample ratios.
  localparam int OVS_LO = 8;
  localparam int OVS_HI = 16;

  // Any unsupported ratio falls back to 16x.
  function automatic int ovs_sanitize(input int ovs);
    return (ovs == OVS_LO) ? OVS_LO : OVS_HI;
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_enabled(input parity_mode_e m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; head word visible while non-empty.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk_sys,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  assign empty   = (level_reg == '0);
  assign o_full  = (level_reg == LVL_FULL);
  assign do_pop  = i_pop & ~empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = i_push & (~o_full | do_pop);

  // Storage array, no reset so it can map onto RAM.
  always_ff @(posedge i_clk_sys) begin
    if (do_push) mem[wr_ptr_reg] <= i_push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Head word is forced to zero while empty so reset and idle outputs are clean.
  assign o_head  = empty ? '0 : mem[rd_ptr_reg];
  assign o_valid = ~empty;
  assign o_level = level_reg;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority voting, break detection and RX FIFO.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVS        = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          i_clk_sys,
  input  logic                          i_rst_n,
  input  logic                          i_uart_rx,
  input  logic [DIV_WIDTH-1:0]          i_baud_div,
  input  logic [1:0]                    i_parity_mode,
  input  logic                          i_two_stop,
  input  logic                          i_clr_err,
  input  logic                          i_rx_ready,
  output logic [DATA_WIDTH-1:0]         o_rx_data,
  output logic                          o_rx_perr,
  output logic                          o_rx_ferr,
  output logic                          o_rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overrun,
  output logic                          o_break
);

  localparam int OVS_EFF = ovs_sanitize(OVS);
  localparam int SW      = $clog2(OVS_EFF);
  localparam int BW      = $clog2(DATA_WIDTH);
  localparam int FW      = DATA_WIDTH + 2;
  localparam logic [SW-1:0] SMP_A    = SW'(OVS_EFF/2 - 1);
  localparam logic [SW-1:0] SMP_B    = SW'(OVS_EFF/2);
  localparam logic [SW-1:0] SMP_C    = SW'(OVS_EFF/2 + 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OVS_EFF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  rx_state_e            state_reg, state_next;
  logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic                 rx_fall;
  logic [DIV_WIDTH-1:0] div_cnt_reg, div_lat_reg;
  logic                 tick;
  logic [SW-1:0]        smp_cnt_reg;
  logic                 s0_reg, s1_reg;
  logic                 vote, vote_now, bit_end, frame_active;
  logic [BW-1:0]        bit_cnt_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                 all_zero_reg, perr_reg, ferr_reg, stop2_reg, two_stop_reg;
  parity_mode_e         par_mode_reg;
  logic                 start_det, push, brk_det;
  logic                 break_reg, overrun_reg;
  logic                 fifo_full, pop;
  logic [FW-1:0]        push_word, head_word;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= i_uart_rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  assign rx_fall = rx_prev_reg & ~rx_sync_reg;

  // Oversample tick generator; divisor is captured only on reload or frame start.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt_reg <= '0;
      div_lat_reg <= '0;
    end else if (start_det || tick) begin
      div_cnt_reg <= '0;
      div_lat_reg <= i_baud_div;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign tick         = (div_cnt_reg == div_lat_reg);
  assign frame_active = (state_reg != ST_IDLE) && (state_reg != ST_BRK_WAIT);
  assign vote_now     = tick && (smp_cnt_reg == SMP_C);
  assign bit_end      = tick && (smp_cnt_reg == SMP_LAST);
  assign vote         = maj3(s0_reg, s1_reg, rx_sync_reg);

  // Per-bit tick position and the first two majority samples.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      smp_cnt_reg <= '0;
      s0_reg      <= 1'b1;
      s1_reg      <= 1'b1;
    end else begin
      if (start_det)                 smp_cnt_reg <= '0;
      else if (tick && frame_active) smp_cnt_reg <= smp_cnt_reg + 1'b1;
      if (tick && (smp_cnt_reg == SMP_A)) s0_reg <= rx_sync_reg;
      if (tick && (smp_cnt_reg == SMP_B)) s1_reg <= rx_sync_reg;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // FSM next-state and frame-level strobes.
  always_comb begin
    state_next = state_reg;
    start_det  = 1'b0;
    push       = 1'b0;
    brk_det    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rx_fall) begin
          start_det  = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (vote_now && vote) state_next = ST_IDLE;
        else if (bit_end)     state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_cnt_reg == BIT_LAST))
          state_next = parity_enabled(par_mode_reg) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (vote_now) begin
          if (!stop2_reg && all_zero_reg && !vote) begin
            brk_det    = 1'b1;
            state_next = ST_BRK_WAIT;
          end else if (!two_stop_reg || stop2_reg) begin
            push       = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_BRK_WAIT: begin
        if (rx_sync_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame datapath: data shift, parity/framing flags and break tracking.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      all_zero_reg <= 1'b1;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      stop2_reg    <= 1'b0;
      two_stop_reg <= 1'b0;
      par_mode_reg <= PAR_NONE;
    end else if (start_det) begin
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      all_zero_reg <= 1'b1;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      stop2_reg    <= 1'b0;
      two_stop_reg <= i_two_stop;
      par_mode_reg <= parity_mode_e'(i_parity_mode);
    end else begin
      if (state_reg == ST_DATA && vote_now) begin
        data_reg <= {vote, data_reg[DATA_WIDTH-1:1]};
        if (vote) all_zero_reg <= 1'b0;
      end
      if (state_reg == ST_DATA && bit_end) bit_cnt_reg <= bit_cnt_reg + 1'b1;
      if (state_reg == ST_PARITY && vote_now) begin
        perr_reg <= (par_mode_reg == PAR_EVEN) ? ^{data_reg, vote} : ~^{data_reg, vote};
        if (vote) all_zero_reg <= 1'b0;
      end
      if (state_reg == ST_STOP && vote_now && !vote) ferr_reg <= 1'b1;
      if (state_reg == ST_STOP && bit_end)           stop2_reg <= 1'b1;
    end
  end

  // The final stop vote is folded in directly since push happens on that cycle.
  assign push_word = {ferr_reg | ~vote, perr_reg, data_reg};
  assign pop       = o_rx_valid & i_rx_ready;

  // Break pulse and sticky overrun; a new overrun wins over a clear.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      break_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      break_reg <= brk_det;
      if (push && fifo_full && !pop) overrun_reg <= 1'b1;
      else if (i_clr_err)            overrun_reg <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk_sys   (i_clk_sys),
    .i_rst_n     (i_rst_n),
    .i_push      (push),
    .i_push_data (push_word),
    .i_pop       (i_rx_ready),
    .o_head      (head_word),
    .o_valid     (o_rx_valid),
    .o_full      (fifo_full),
    .o_level     (o_fifo_level)
  );

  assign o_rx_data = head_word[DATA_WIDTH-1:0];
  assign o_rx_perr = head_word[DATA_WIDTH];
  assign o_rx_ferr = head_word[DATA_WIDTH+1];
  assign o_overrun = overrun_reg;
  assign o_break   = break_reg;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs: frames are driven bit by bit, expected words queued.
module tb_uart_rx_ovs;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int DIVW  = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx = 1'b1;
  logic [DIVW-1:0] baud_div = 16'd26;
  logic [1:0]      parity_mode = 2'b00;
  logic            two_stop = 1'b0;
  logic            clr_err = 1'b0;
  logic            rx_ready = 1'b1;
  logic [DW-1:0]   rx_data;
  logic            rx_perr, rx_ferr, rx_valid, overrun, brk;
  logic [LW-1:0]   fifo_level;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int brk_cnt = 0;
  int rise_cyc = 0;
  int s_cyc = 0;
  logic valid_d = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] got_w, exp_w;

  uart_rx_ovs #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .OVS        (16),
    .DIV_WIDTH  (DIVW)
  ) dut (
    .i_clk_sys     (clk),
    .i_rst_n       (rst_n),
    .i_uart_rx     (rx),
    .i_baud_div    (baud_div),
    .i_parity_mode (parity_mode),
    .i_two_stop    (two_stop),
    .i_clr_err     (clr_err),
    .i_rx_ready    (rx_ready),
    .o_rx_data     (rx_data),
    .o_rx_perr     (rx_perr),
    .o_rx_ferr     (rx_ferr),
    .o_rx_valid    (rx_valid),
    .o_fifo_level  (fifo_level),
    .o_overrun     (overrun),
    .o_break       (brk)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int ncyc);
    rx = b;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, optional parity, one or two stop bits, then idle.
  task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit,
                            input bit stop1, input bit stop2_en, input bit stop2, input int bit_cyc);
    drive_bit(1'b0, bit_cyc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bit_cyc);
    if (par_en)   drive_bit(par_bit, bit_cyc);
    drive_bit(stop1, bit_cyc);
    if (stop2_en) drive_bit(stop2, bit_cyc);
    drive_bit(1'b1, 2 * bit_cyc);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_val("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: break pulses, valid rise time and scoreboard pops.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (brk) brk_cnt++;
      if (rx_valid && !valid_d) rise_cyc = cyc;
      valid_d = rx_valid;
      if (rx_valid && rx_ready) begin
        got_w = {rx_ferr, rx_perr, rx_data};
        check_val("q_occupied", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check_val("rx_word", 32'(got_w), 32'(exp_w));
        end
        $display("rx word data=%02h perr=%0b ferr=%0b level=%0d", rx_data, rx_perr, rx_ferr, fifo_level);
      end
    end
  end

  // Hard time limit.
  initial begin
    #(60000 * 20);
    $display("FAIL watchdog: got time limit expired required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_valid",   32'(rx_valid),   32'd0);
    check_val("rst_level",   32'(fifo_level), 32'd0);
    check_val("rst_overrun", 32'(overrun),    32'd0);
    check_val("rst_break",   32'(brk),        32'd0);
    check_val("rst_data",    32'(rx_data),    32'd0);
    check_val("rst_perr",    32'(rx_perr),    32'd0);
    check_val("rst_ferr",    32'(rx_ferr),    32'd0);

    // 8N1 at divisor 26: 432 clocks per bit, stop bit centre ~4104 clocks after start edge.
    repeat (20) @(posedge clk);
    #1 s_cyc = cyc;
    exp_q.push_back(10'h0A5);
    send_frame(8'hA5, 0, 0, 1, 0, 0, 432);
    wait_drain(2000);
    check_val("valid_latency", 32'((rise_cyc - s_cyc) >= 4104 && (rise_cyc - s_cyc) <= 4170), 32'd1);

    // Faster divisor for the rest: 64 clocks per bit.
    baud_div = 16'd3;

    parity_mode = 2'b01;
    exp_q.push_back(10'h103);
    send_frame(8'h03, 1, 1, 1, 0, 0, 64);
    parity_mode = 2'b10;
    exp_q.push_back(10'h003);
    send_frame(8'h03, 1, 1, 1, 0, 0, 64);
    parity_mode = 2'b11;
    exp_q.push_back(10'h03C);
    send_frame(8'h3C, 0, 0, 1, 0, 0, 64);
    parity_mode = 2'b00;
    wait_drain(500);

    // Glitch of 3 ticks must be rejected; a following frame must still decode.
    drive_bit(1'b0, 12);
    drive_bit(1'b1, 192);
    check_val("glitch_level", 32'(fifo_level), 32'd0);
    check_val("glitch_valid", 32'(rx_valid),   32'd0);
    exp_q.push_back(10'h096);
    send_frame(8'h96, 0, 0, 1, 0, 0, 64);
    wait_drain(500);

    // Framing errors: two stop bits with second low, and single low stop bit.
    two_stop = 1'b1;
    exp_q.push_back(10'h281);
    send_frame(8'h81, 0, 0, 1, 1, 0, 64);
    exp_q.push_back(10'h042);
    send_frame(8'h42, 0, 0, 1, 1, 1, 64);
    two_stop = 1'b0;
    exp_q.push_back(10'h27E);
    send_frame(8'h7E, 0, 0, 0, 0, 0, 64);
    wait_drain(500);

    // Break: line low for 12 bit times.
    check_val("pre_break_cnt", 32'(brk_cnt), 32'd0);
    drive_bit(1'b0, 12 * 64);
    drive_bit(1'b1, 128);
    check_val("break_pulses", 32'(brk_cnt),    32'd1);
    check_val("break_level",  32'(fifo_level), 32'd0);
    exp_q.push_back(10'h05A);
    send_frame(8'h5A, 0, 0, 1, 0, 0, 64);
    wait_drain(500);

    // Overrun: 17 words into a 16-deep FIFO with the consumer stalled.
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(10'(i));
      send_frame(8'(i), 0, 0, 1, 0, 0, 64);
    end
    @(negedge clk);
    check_val("ovr_level", 32'(fifo_level), 32'd16);
    check_val("ovr_flag",  32'(overrun),    32'd1);
    check_val("ovr_head",  32'(rx_data),    32'd0);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    wait_drain(200);
    @(negedge clk);
    check_val("ovr_level_empty", 32'(fifo_level), 32'd0);
    check_val("ovr_sticky",      32'(overrun),    32'd1);
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
    check_val("ovr_cleared", 32'(overrun), 32'd0);
    check_val("end_queue",   32'(exp_q.size()), 32'd0);

    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter OVS, default 16, oversample ticks per bit (8 or 16).
REQ-004 SHALL have parameter DIV_WIDTH, default 16, width of the baud divisor.
REQ-005 SHALL have port i_clk_sys  in  1  system clock.
REQ-006 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_uart_rx  in  1  asynchronous serial input, idle high.
REQ-008 SHALL have port i_baud_div  in  DIV_WIDTH  system clocks per oversample tick minus 1.
REQ-009 SHALL have port i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
REQ-010 SHALL have port i_two_stop  in  1  1 = two stop bits checked.
REQ-011 SHALL have port i_clr_err  in  1  clears sticky o_overrun.
REQ-012 SHALL have port i_rx_ready  in  1  consumer accepts head word.
REQ-013 SHALL have ports o_rx_data (DATA_WIDTH), o_rx_perr (1), o_rx_ferr (1)  out  FIFO head word and its parity/framing error flags.
REQ-014 SHALL have port o_rx_valid  out  1  FIFO non-empty.
REQ-015 SHALL have port o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-016 SHALL have ports o_overrun (sticky) and o_break (1-cycle pulse)  out  1 each.

Function
REQ-017 i_uart_rx SHALL pass a 2-flop synchroniser (reset value 1) before any use.
REQ-018 Tick counter SHALL count 0..i_baud_div, pulsing tick on reload; i_baud_div=0 gives a tick every cycle; a changed divisor takes effect at next reload.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-020 IDLE: synced 1->0 transition SHALL zero tick and sample counters and enter START.
REQ-021 Each bit SHALL be decided by 2-of-3 majority of samples at ticks OVS/2-1, OVS/2, OVS/2+1.
REQ-022 START: majority 1 SHALL return to IDLE with no push (glitch reject); else enter DATA after OVS ticks.
REQ-023 DATA: DATA_WIDTH bits, LSB first; then PARITY if mode 01/10, else STOP.
REQ-024 PARITY: perr SHALL be 1 when XOR(data, parity bit) != 0 for even, == 0 for odd; perr is 0 when parity is off.
REQ-025 STOP: 1 or 2 stop bits; any stop bit voting 0 SHALL set ferr; exit occurs at mid-sample of last stop bit, back to IDLE.
REQ-026 Break: all data bits, parity bit (if present) and first stop bit 0 SHALL pulse o_break one cycle, push nothing, enter BRK_WAIT until synced line is 1, then IDLE.
REQ-027 Non-break frames, including errored ones, SHALL be pushed as {ferr, perr, data}.
REQ-028 FIFO SHALL be first-word-fall-through; o_rx_valid rises the cycle after push; pop on o_rx_valid & i_rx_ready.
REQ-029 Push when full without simultaneous pop SHALL drop the word and set o_overrun; push and pop in the same cycle when full SHALL both succeed, no overrun.
REQ-030 o_overrun SHALL stay set until i_clr_err; set wins over simultaneous clear.
REQ-031 Pop on empty SHALL be ignored; level never wraps.

Reset
REQ-032 Reset SHALL force FSM to IDLE, counters and FIFO pointers to 0, synchroniser to 1, o_rx_valid/o_overrun/o_break/o_fifo_level to 0, o_rx_data/o_rx_perr/o_rx_ferr to 0, aborting any frame in progress.

Structure
REQ-033 Parity-mode encodings, FSM state encodings and OVS legal values SHALL live in shared package uart_pkg.
REQ-034 FIFO SHALL be sub-module uart_rx_fifo (width DATA_WIDTH+2, depth FIFO_DEPTH).

Verification
REQ-035 50 MHz, OVS=16, i_baud_div=26, 8N1, send 0xA5 -> one word 0xA5, perr=0, ferr=0, o_rx_valid one cycle after stop mid-sample.
REQ-036 Even parity, send 0x03 with parity bit 1 -> word 0x03, perr=1; same with odd -> perr=0.
REQ-037 Line low for 3 ticks only -> no push, FSM back in IDLE.
REQ-038 i_rx_ready=0, send 17 bytes 0x00..0x10 into depth 16 -> level 16, o_overrun=1, reads return 0x00..0x0F, i_clr_err clears flag.
REQ-039 i_two_stop=1, second stop bit 0 -> word pushed with ferr=1.
REQ-040 Line held low 12 bit-times then released -> exactly one o_break pulse, level unchanged, next frame 0x5A received correctly.
